// File: rtl/coh_bus_pkg.sv
// Shared definitions for the coherence bus arbiter: opcode encodings, FSM
// states, sizing constants and a small index-to-one-hot helper.
// The optional bus timeout is enabled by defining BUS_TIMEOUT_EN.
package coh_bus_pkg;

    localparam int NUM_REQ     = 4;   // cache controllers on the bus
    localparam int ADDR_W      = 8;   // block-address width
    localparam int IDX_W       = 2;   // requester index width (4 requesters)
    localparam int TIMEOUT_MAX = 15;  // wait cycles before a timeout completes the transaction

    typedef enum logic [1:0] {
        OP_RSVD       = 2'b00,
        OP_READ_MISS  = 2'b01,
        OP_WRITE_MISS = 2'b10,
        OP_INVALIDATE = 2'b11
    } coh_op_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BCAST    = 3'd1,
        ST_WB_WAIT  = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_DONE     = 3'd4
    } coh_state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/coherence_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: searches the eligible vector starting
// one past the last granted index and returns a one-hot grant, its index
// and whether anything was eligible.
module rr_picker
    import coh_bus_pkg::*;
#(
    parameter int NUM_REQ = coh_bus_pkg::NUM_REQ
) (
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down to the nearest so the nearest eligible wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = last_i + IDX_W'(i);
            if (elig_i[cand]) begin
                grant_o = idx_to_onehot(cand);
                idx_o   = cand;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Snooping-bus arbiter for four cache controllers. Grants one transaction
// at a time round-robin, broadcasts it for one cycle, waits for a snooper
// writeback and/or memory fill, then pulses done to the requester.
// Defining BUS_TIMEOUT_EN adds a 4-bit wait timeout that completes the
// transaction with bus_err; otherwise waits are unbounded and bus_err is 0.
//
// Handshake: req[i] with its op/addr is held by the requester until done[i]
// pulses; the arbiter latches op/addr at grant, so later changes on the
// request lines do not affect the transaction in flight. mem_rd is held
// until the cycle mem_ack is seen; wb_done/mem_ack count only in their
// respective wait states.
module coherence_bus_arbiter
    import coh_bus_pkg::*;
#(
    parameter int NUM_REQ = coh_bus_pkg::NUM_REQ,
    parameter int ADDR_W  = coh_bus_pkg::ADDR_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        snoop_wb,
    input  logic                      wb_done,
    input  logic                      mem_ack,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      bus_valid,
    output logic [1:0]                bus_op,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [IDX_W-1:0]          bus_src,
    output logic                      mem_rd,
    output logic                      bus_err,
    output coh_state_t                state_dbg
);

    logic [1:0]        op_arr   [NUM_REQ];
    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] elig;

    // Split the flat request buses per requester; reserved opcodes are never eligible.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g]   = req_op[2*g +: 2];
        assign addr_arr[g] = req_addr[ADDR_W*g +: ADDR_W];
        assign elig[g]     = req[g] && (req_op[2*g +: 2] != OP_RSVD);
    end

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    coh_state_t         state_q;
    logic [IDX_W-1:0]   src_q;
    logic [1:0]         op_q;
    logic [IDX_W-1:0]   last_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic               bus_valid_q;
    logic [1:0]         bus_op_q;
    logic [ADDR_W-1:0]  bus_addr_q;
    logic [IDX_W-1:0]   bus_src_q;
    logic               mem_rd_q;
`ifdef BUS_TIMEOUT_EN
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT_MAX - 1);
    logic [3:0]         cnt_q;
    logic               bus_err_q;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .elig_i  (elig),
        .last_i  (last_q),
        .grant_o (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Transaction FSM with all bus-facing outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            op_q        <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            done_q      <= '0;
            bus_valid_q <= 1'b0;
            bus_op_q    <= '0;
            bus_addr_q  <= '0;
            bus_src_q   <= '0;
            mem_rd_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            // One-cycle pulses default low.
            done_q      <= '0;
            bus_valid_q <= 1'b0;
            bus_op_q    <= '0;
            bus_addr_q  <= '0;
            bus_src_q   <= '0;
`ifdef BUS_TIMEOUT_EN
            bus_err_q   <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        src_q       <= pick_idx;
                        op_q        <= op_arr[pick_idx];
                        last_q      <= pick_idx;
                        gnt_q       <= pick_gnt;
                        bus_valid_q <= 1'b1;
                        bus_op_q    <= op_arr[pick_idx];
                        bus_addr_q  <= addr_arr[pick_idx];
                        bus_src_q   <= pick_idx;
                        state_q     <= ST_BCAST;
                    end
                end
                ST_BCAST: begin
`ifdef BUS_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                    // The granted requester's own snoop response is meaningless.
                    if ((snoop_wb & ~gnt_q) != '0) begin
                        state_q <= ST_WB_WAIT;
                    end else if (op_q == OP_INVALIDATE) begin
                        done_q  <= idx_to_onehot(src_q);
                        state_q <= ST_DONE;
                    end else begin
                        mem_rd_q <= 1'b1;
                        state_q  <= ST_MEM_WAIT;
                    end
                end
                ST_WB_WAIT: begin
                    if (wb_done) begin
`ifdef BUS_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                        if (op_q == OP_INVALIDATE) begin
                            done_q  <= idx_to_onehot(src_q);
                            state_q <= ST_DONE;
                        end else begin
                            mem_rd_q <= 1'b1;
                            state_q  <= ST_MEM_WAIT;
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        done_q    <= idx_to_onehot(src_q);
                        bus_err_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
`endif
                end
                ST_MEM_WAIT: begin
                    if (mem_ack) begin
                        mem_rd_q <= 1'b0;
                        done_q   <= idx_to_onehot(src_q);
                        state_q  <= ST_DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        mem_rd_q  <= 1'b0;
                        done_q    <= idx_to_onehot(src_q);
                        bus_err_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
`endif
                end
                ST_DONE: begin
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q    <= '0;
                    mem_rd_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign bus_valid = bus_valid_q;
    assign bus_op    = bus_op_q;
    assign bus_addr  = bus_addr_q;
    assign bus_src   = bus_src_q;
    assign mem_rd    = mem_rd_q;
    assign state_dbg = state_q;
`ifdef BUS_TIMEOUT_EN
    assign bus_err   = bus_err_q;
`else
    assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter: reset, invalidate fast path,
// round-robin fairness, snooper writeback, reset mid-transaction and the
// unbounded / timeout wait (selected by BUS_TIMEOUT_EN).
module tb_coherence_bus_arbiter;
    import coh_bus_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_op;
    logic [31:0] req_addr;
    logic [3:0]  snoop_wb;
    logic        wb_done;
    logic        mem_ack;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        bus_valid;
    logic [1:0]  bus_op;
    logic [7:0]  bus_addr;
    logic [1:0]  bus_src;
    logic        mem_rd;
    logic        bus_err;
    coh_state_t  state_dbg;

    int n_vec = 0;
    int n_err = 0;

    coherence_bus_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .snoop_wb  (snoop_wb),
        .wb_done   (wb_done),
        .mem_ack   (mem_ack),
        .gnt       (gnt),
        .done      (done),
        .bus_valid (bus_valid),
        .bus_op    (bus_op),
        .bus_addr  (bus_addr),
        .bus_src   (bus_src),
        .mem_rd    (mem_rd),
        .bus_err   (bus_err),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        req      = '0;
        req_op   = '0;
        req_addr = '0;
        snoop_wb = '0;
        wb_done  = 1'b0;
        mem_ack  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = '0; req_op = '0; req_addr = '0; snoop_wb = '0; wb_done = 1'b0; mem_ack = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({gnt, done, bus_valid, bus_op, bus_addr, bus_src, mem_rd, bus_err} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0", {gnt, done, bus_valid, bus_op, bus_addr, bus_src, mem_rd, bus_err});
        end
        n_vec++;
        if (state_dbg !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d required %0d", state_dbg, ST_IDLE);
        end
        reset = 1'b0;
        tick();
    endtask

    // Invalidate with no writeback: done two cycles after the IDLE sample;
    // the requester's own snoop_wb is masked and request changes are ignored.
    task automatic test_invalidate();
        apply_reset();
        req = 4'b0001; req_op = 8'b0000_0011; req_addr = 32'h0000_002A;
        tick();
        n_vec++;
        if ({bus_valid, bus_op, bus_addr, bus_src, gnt, done} !== {1'b1, 2'b11, 8'h2A, 2'd0, 4'b0001, 4'b0000}) begin
            n_err++;
            $display("FAIL inv_bcast: got %h required %h", {bus_valid, bus_op, bus_addr, bus_src, gnt, done},
                     {1'b1, 2'b11, 8'h2A, 2'd0, 4'b0001, 4'b0000});
        end
        req = 4'b0000; req_op = 8'b0000_0001; req_addr = 32'h0000_00FF; snoop_wb = 4'b0001;
        tick();
        snoop_wb = 4'b0000;
        n_vec++;
        if ({done, gnt, bus_valid} !== {4'b0001, 4'b0001, 1'b0}) begin
            n_err++;
            $display("FAIL inv_done: got %h required %h", {done, gnt, bus_valid}, {4'b0001, 4'b0001, 1'b0});
        end
        tick();
        n_vec++;
        if ({done, gnt, state_dbg} !== {4'b0000, 4'b0000, ST_IDLE}) begin
            n_err++;
            $display("FAIL inv_idle: got %h required %h", {done, gnt, state_dbg}, {4'b0000, 4'b0000, ST_IDLE});
        end
    endtask

    // All four request read misses; grants rotate 0,1,2,3,0 with one IDLE cycle between.
    task automatic test_round_robin();
        logic [1:0] exp_src;
        logic [3:0] exp_oh;
        apply_reset();
        req = 4'b1111; req_op = 8'b01_01_01_01; req_addr = 32'h43_42_41_40;
        for (int k = 0; k < 5; k++) begin
            exp_src = 2'(k);
            exp_oh  = 4'b0001 << exp_src;
            tick();
            n_vec++;
            if ({bus_valid, bus_src, gnt, bus_addr, bus_op} !== {1'b1, exp_src, exp_oh, 8'h40 + 8'(exp_src), 2'b01}) begin
                n_err++;
                $display("FAIL rr_grant%0d: got %h required %h", k, {bus_valid, bus_src, gnt, bus_addr, bus_op},
                         {1'b1, exp_src, exp_oh, 8'h40 + 8'(exp_src), 2'b01});
            end
            tick();
            n_vec++;
            if ({mem_rd, done} !== {1'b1, 4'b0000}) begin
                n_err++;
                $display("FAIL rr_memrd%0d: got %h required %h", k, {mem_rd, done}, {1'b1, 4'b0000});
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            n_vec++;
            if ({done, mem_rd} !== {exp_oh, 1'b0}) begin
                n_err++;
                $display("FAIL rr_done%0d: got %h required %h", k, {done, mem_rd}, {exp_oh, 1'b0});
            end
            tick();
            n_vec++;
            if ({gnt, bus_valid, done} !== 9'h0) begin
                n_err++;
                $display("FAIL rr_idle%0d: got %h required 0", k, {gnt, bus_valid, done});
            end
        end
        req = '0;
        tick();
    endtask

    // Write miss from 1 with snoopers 1 and 2 claiming Modified: masked to 2, writeback then fill.
    task automatic test_writeback();
        apply_reset();
        req = 4'b0010; req_op = 8'b00_00_10_00; req_addr = 32'h0000_5500;
        tick();
        n_vec++;
        if ({bus_valid, bus_src, bus_op, bus_addr, gnt} !== {1'b1, 2'd1, 2'b10, 8'h55, 4'b0010}) begin
            n_err++;
            $display("FAIL wb_bcast: got %h required %h", {bus_valid, bus_src, bus_op, bus_addr, gnt},
                     {1'b1, 2'd1, 2'b10, 8'h55, 4'b0010});
        end
        snoop_wb = 4'b0110;
        mem_ack  = 1'b1;
        tick();
        snoop_wb = 4'b0000;
        n_vec++;
        if ({state_dbg, mem_rd, done} !== {ST_WB_WAIT, 1'b0, 4'b0000}) begin
            n_err++;
            $display("FAIL wb_enter: got %h required %h", {state_dbg, mem_rd, done}, {ST_WB_WAIT, 1'b0, 4'b0000});
        end
        tick();
        mem_ack = 1'b0;
        n_vec++;
        if ({state_dbg, mem_rd, done} !== {ST_WB_WAIT, 1'b0, 4'b0000}) begin
            n_err++;
            $display("FAIL wb_ignore_ack: got %h required %h", {state_dbg, mem_rd, done}, {ST_WB_WAIT, 1'b0, 4'b0000});
        end
        tick();
        wb_done = 1'b1;
        tick();
        n_vec++;
        if ({state_dbg, mem_rd, done} !== {ST_MEM_WAIT, 1'b1, 4'b0000}) begin
            n_err++;
            $display("FAIL wb_to_mem: got %h required %h", {state_dbg, mem_rd, done}, {ST_MEM_WAIT, 1'b1, 4'b0000});
        end
        tick();
        wb_done = 1'b0;
        n_vec++;
        if ({state_dbg, mem_rd} !== {ST_MEM_WAIT, 1'b1}) begin
            n_err++;
            $display("FAIL wb_ignore_wbdone: got %h required %h", {state_dbg, mem_rd}, {ST_MEM_WAIT, 1'b1});
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        req = '0;
        n_vec++;
        if ({done, mem_rd, gnt, bus_err} !== {4'b0010, 1'b0, 4'b0010, 1'b0}) begin
            n_err++;
            $display("FAIL wb_done: got %h required %h", {done, mem_rd, gnt, bus_err}, {4'b0010, 1'b0, 4'b0010, 1'b0});
        end
        tick();
    endtask

    // Reset while waiting for memory aborts silently; requester 3 then wins.
    task automatic test_reset_midflight();
        apply_reset();
        req = 4'b0001; req_op = 8'b00_00_00_01; req_addr = 32'h0000_0011;
        tick();
        tick();
        n_vec++;
        if (mem_rd !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_memrd: got %b required 1", mem_rd);
        end
        reset = 1'b1;
        req   = '0;
        tick();
        n_vec++;
        if ({gnt, done, bus_valid, bus_op, bus_addr, bus_src, mem_rd, bus_err, state_dbg} !== {24'h0, ST_IDLE}) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %h required %h",
                     {gnt, done, bus_valid, bus_op, bus_addr, bus_src, mem_rd, bus_err, state_dbg}, {24'h0, ST_IDLE});
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if ({done, gnt} !== 8'h00) begin
            n_err++;
            $display("FAIL rst_mid_nodone: got %h required 0", {done, gnt});
        end
        req = 4'b1000; req_op = 8'b11_00_00_00; req_addr = 32'h7700_0000;
        tick();
        n_vec++;
        if ({bus_src, gnt, bus_addr, bus_op} !== {2'd3, 4'b1000, 8'h77, 2'b11}) begin
            n_err++;
            $display("FAIL rst_mid_grant3: got %h required %h", {bus_src, gnt, bus_addr, bus_op}, {2'd3, 4'b1000, 8'h77, 2'b11});
        end
        tick();
        req = '0;
        n_vec++;
        if (done !== 4'b1000) begin
            n_err++;
            $display("FAIL rst_mid_done3: got %b required 1000", done);
        end
        tick();
    endtask

    // Memory never answers: timeout after 15 wait cycles, or an unbounded wait.
    task automatic test_timeout();
        apply_reset();
        req = 4'b0001; req_op = 8'b00_00_00_01; req_addr = 32'h0000_0033;
        tick();
        tick();
`ifdef BUS_TIMEOUT_EN
        for (int k = 0; k < 14; k++) begin
            tick();
            n_vec++;
            if ({mem_rd, done, bus_err} !== {1'b1, 4'b0000, 1'b0}) begin
                n_err++;
                $display("FAIL to_wait%0d: got %h required %h", k, {mem_rd, done, bus_err}, {1'b1, 4'b0000, 1'b0});
            end
        end
        tick();
        n_vec++;
        if ({done, bus_err, mem_rd} !== {4'b0001, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL to_expire: got %h required %h", {done, bus_err, mem_rd}, {4'b0001, 1'b1, 1'b0});
        end
        req = '0;
        tick();
        n_vec++;
        if ({done, bus_err} !== 5'h0) begin
            n_err++;
            $display("FAIL to_pulse_end: got %h required 0", {done, bus_err});
        end
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            n_vec++;
            if ({mem_rd, done, bus_err} !== {1'b1, 4'b0000, 1'b0}) begin
                n_err++;
                $display("FAIL nowait%0d: got %h required %h", k, {mem_rd, done, bus_err}, {1'b1, 4'b0000, 1'b0});
            end
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        req = '0;
        n_vec++;
        if ({done, bus_err, mem_rd} !== {4'b0001, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL nowait_done: got %h required %h", {done, bus_err, mem_rd}, {4'b0001, 1'b0, 1'b0});
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_invalidate();
        test_round_robin();
        test_writeback();
        test_reset_midflight();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
